// File: rtl/wdt_pkg.sv
// Shared types for the windowed watchdog: FSM state encoding
// and the count-direction constants.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WARN    = 2'd2,
        EXPIRED = 2'd3
    } wdt_state_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/windowed_watchdog_if.sv
// Control/status bundle between a watchdog client (master)
// and the watchdog (slave).
interface windowed_watchdog_if #(
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 4
);
    logic                 en;
    logic                 up_dn;
    logic                 service;
    logic                 clr;
    logic [PRE_WIDTH-1:0] prescale;
    logic [CNT_WIDTH-1:0] timeout_val;
    logic [CNT_WIDTH-1:0] warn_val;
    logic [CNT_WIDTH-1:0] window_val;
    logic [CNT_WIDTH-1:0] count;
    logic                 warn;
    logic                 timeout;
    logic                 early_fault;

    modport master (
        output en, up_dn, service, clr, prescale,
        output timeout_val, warn_val, window_val,
        input  count, warn, timeout, early_fault
    );

    modport slave (
        input  en, up_dn, service, clr, prescale,
        input  timeout_val, warn_val, window_val,
        output count, warn, timeout, early_fault
    );
endinterface

// File: rtl/wdt_prescaler.sv
// Tick generator: one tick every prescale+1 clocks while run
// is high; clear restarts the period.
module wdt_prescaler #(
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 tick
);
    logic [PRE_WIDTH-1:0] r_pre;

    assign tick = run && (r_pre == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (clear) begin
            r_pre <= '0;
        end else if (run) begin
            r_pre <= tick ? '0 : r_pre + PRE_WIDTH'(1);
        end
    end
endmodule

// File: rtl/windowed_watchdog.sv
// Windowed watchdog timer with warning stage and sticky expiry.
// Define WDT_WINDOW_EN to fault on services before window_val.
module windowed_watchdog
    import wdt_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    windowed_watchdog_if.slave  bus
);
    localparam logic [CNT_WIDTH:0] ONE_W = (CNT_WIDTH+1)'(1);

    wdt_state_e           r_state;
    wdt_state_e           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic                 r_warn;
    logic                 r_timeout;
    logic                 w_warn_nxt;
    logic                 w_timeout_nxt;

    logic                 w_run;
    logic                 w_tick;
    logic                 w_reload;
    logic                 w_adv;
    logic                 w_term;
    logic                 w_early_svc;
    logic [CNT_WIDTH-1:0] w_elapsed;
    logic [CNT_WIDTH:0]   w_el_p1;
    logic [CNT_WIDTH:0]   w_el_nxt;
    logic [CNT_WIDTH-1:0] w_terminal;

    assign w_run      = (r_state == RUN) || (r_state == WARN);
    assign w_elapsed  = (r_dir == UP) ? r_count
                                      : bus.timeout_val - r_count;
    assign w_el_p1    = {1'b0, w_elapsed} + ONE_W;
    assign w_el_nxt   = w_tick ? w_el_p1 : {1'b0, w_elapsed};
    // Terminal when the pending tick lands on (or past) timeout_val.
    assign w_term     = w_el_p1 >= {1'b0, bus.timeout_val};
    assign w_terminal = (r_dir == UP) ? bus.timeout_val : '0;

    wdt_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (w_run),
        .clear    (w_reload),
        .prescale (bus.prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_dir   <= UP;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_adv       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = RUN;
                    w_reload    = 1'b1;
                end
            end
            RUN, WARN: begin
                if (!bus.en) begin
                    w_state_nxt = IDLE;
                end else if (w_early_svc) begin
                    w_state_nxt = EXPIRED;
                end else if (bus.service) begin
                    w_state_nxt = RUN;
                    w_reload    = 1'b1;
                end else begin
                    w_adv = w_tick;
                    if (w_tick && w_term) begin
                        w_state_nxt = EXPIRED;
                    end else if (r_state == RUN &&
                                 w_el_nxt >= {1'b0, bus.warn_val}) begin
                        w_state_nxt = WARN;
                    end
                end
            end
            EXPIRED: begin
                if (bus.clr) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (w_reload) begin
            w_dir_nxt   = bus.up_dn;
            w_count_nxt = (bus.up_dn == UP) ? '0 : bus.timeout_val;
        end else if (w_adv) begin
            if (w_term) begin
                w_count_nxt = w_terminal;
            end else if (r_dir == UP) begin
                w_count_nxt = r_count + CNT_WIDTH'(1);
            end else begin
                w_count_nxt = r_count - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_warn_nxt    = (w_state_nxt == WARN);
        w_timeout_nxt = (w_state_nxt == EXPIRED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warn    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_warn    <= w_warn_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.count   = r_count;
    assign bus.warn    = r_warn;
    assign bus.timeout = r_timeout;

`ifdef WDT_WINDOW_EN
    logic r_early;
    logic w_early_nxt;

    assign w_early_svc = w_run && bus.service &&
                         (w_elapsed < bus.window_val);
    // Only clr (or reset) leaves EXPIRED, so the flag follows it.
    assign w_early_nxt = (w_state_nxt == EXPIRED) &&
                         (r_early || (bus.en && w_early_svc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_early <= 1'b0;
        end else begin
            r_early <= w_early_nxt;
        end
    end

    assign bus.early_fault = r_early;
`else
    assign w_early_svc     = 1'b0;
    assign bus.early_fault = 1'b0;
`endif
endmodule

// File: tb/tb_windowed_watchdog.sv
// Directed bench for windowed_watchdog (CNT_WIDTH=5).
// Build with WDT_WINDOW_EN to match a windowed DUT build.
module tb_windowed_watchdog;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    int   exp_cnt;

    windowed_watchdog_if #(.CNT_WIDTH(5), .PRE_WIDTH(4)) bus ();

    windowed_watchdog #(
        .CNT_WIDTH (5),
        .PRE_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.service = 1'b0;
        bus.clr     = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst             = 1'b1;
        bus.en          = 1'b0;
        bus.up_dn       = 1'b1;
        bus.service     = 1'b0;
        bus.clr         = 1'b0;
        bus.prescale    = 4'd0;
        bus.timeout_val = 5'd20;
        bus.warn_val    = 5'd15;
        bus.window_val  = 5'd4;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_warn", bus.warn, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_early", bus.early_fault, 0);
        step(1);
        rst = 1'b0;

        // up mode, no service
        bus.en = 1'b1;
        step(1);
        chk("up_entry", bus.count, 0);
        step(14);
        chk("up_c14", bus.count, 14);
        chk("up_c14_warn", bus.warn, 0);
        step(1);
        chk("up_c15", bus.count, 15);
        chk("up_c15_warn", bus.warn, 1);
        step(4);
        chk("up_c19", bus.count, 19);
        chk("up_c19_to", bus.timeout, 0);
        step(1);
        chk("up_c20", bus.count, 20);
        chk("up_c20_to", bus.timeout, 1);
        chk("up_c20_warn", bus.warn, 0);
        step(3);
        chk("up_hold", bus.count, 20);
        bus.service = 1'b1;
        step(1);
        bus.service = 1'b0;
        chk("exp_svc_ign_cnt", bus.count, 20);
        chk("exp_svc_ign_to", bus.timeout, 1);
        bus.clr     = 1'b1;
        bus.service = 1'b1;
        step(1);
        bus.clr     = 1'b0;
        bus.service = 1'b0;
        chk("clr_wins_to", bus.timeout, 0);
        chk("clr_wins_cnt", bus.count, 20);
        step(1);
        chk("rerun_cnt", bus.count, 0);

        // periodic service every 10 cycles
        rst_pulse();
        bus.en = 1'b1;
        step(1);
        exp_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (exp_cnt == 9) bus.service = 1'b1;
            step(1);
            bus.service = 1'b0;
            exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
            chk("svc_cnt", bus.count, exp_cnt);
            chk("svc_flags", {bus.warn, bus.timeout}, 0);
        end

        // down mode
        rst_pulse();
        bus.up_dn = 1'b0;
        bus.en    = 1'b1;
        step(1);
        chk("dn_entry", bus.count, 20);
        bus.up_dn = 1'b1;
        step(5);
        chk("dn_c15", bus.count, 15);
        step(9);
        chk("dn_c6_warn", bus.warn, 0);
        step(1);
        chk("dn_c5", bus.count, 5);
        chk("dn_c5_warn", bus.warn, 1);
        step(4);
        chk("dn_c1_to", bus.timeout, 0);
        step(1);
        chk("dn_c0", bus.count, 0);
        chk("dn_c0_to", bus.timeout, 1);
        chk("dn_c0_warn", bus.warn, 0);
        bus.en  = 1'b0;
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        chk("dn_clr_to", bus.timeout, 0);
        chk("dn_clr_warn", bus.warn, 0);

        // prescale = 3
        rst_pulse();
        bus.prescale = 4'd3;
        bus.up_dn    = 1'b1;
        bus.en       = 1'b1;
        step(1);
        step(3);
        chk("ps_c0", bus.count, 0);
        step(1);
        chk("ps_c1", bus.count, 1);
        step(72);
        chk("ps_c19", bus.count, 19);
        step(3);
        chk("ps_c19_hold", bus.count, 19);
        chk("ps_to_lo", bus.timeout, 0);
        step(1);
        chk("ps_c20", bus.count, 20);
        chk("ps_to_hi", bus.timeout, 1);
        bus.prescale = 4'd0;

        // service on terminal tick wins
        rst_pulse();
        bus.en = 1'b1;
        step(20);
        chk("race_c19", bus.count, 19);
        bus.service = 1'b1;
        step(1);
        bus.service = 1'b0;
        chk("race_cnt", bus.count, 0);
        chk("race_to", bus.timeout, 0);
        chk("race_warn", bus.warn, 0);

        // timeout_val = 0
        rst_pulse();
        bus.timeout_val = 5'd0;
        bus.en = 1'b1;
        step(1);
        chk("t0_entry_to", bus.timeout, 0);
        step(1);
        chk("t0_to", bus.timeout, 1);
        chk("t0_cnt", bus.count, 0);
        bus.timeout_val = 5'd20;

        // early service at elapsed = 2
        rst_pulse();
        bus.en = 1'b1;
        step(3);
        chk("win_c2", bus.count, 2);
        bus.service = 1'b1;
        step(1);
        bus.service = 1'b0;
`ifdef WDT_WINDOW_EN
        chk("win_early", bus.early_fault, 1);
        chk("win_to", bus.timeout, 1);
        chk("win_cnt", bus.count, 2);
        bus.en  = 1'b0;
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        chk("win_clr_early", bus.early_fault, 0);
        chk("win_clr_to", bus.timeout, 0);
`else
        chk("win_early", bus.early_fault, 0);
        chk("win_to", bus.timeout, 0);
        chk("win_cnt", bus.count, 0);
`endif

        // legal service inside the open window
        rst_pulse();
        bus.en = 1'b1;
        step(6);
        bus.service = 1'b1;
        step(1);
        bus.service = 1'b0;
        chk("open_cnt", bus.count, 0);
        chk("open_early", bus.early_fault, 0);

        // en low holds count
        step(3);
        bus.en = 1'b0;
        step(2);
        chk("hold_cnt", bus.count, 3);
        chk("hold_warn", bus.warn, 0);

        // async reset mid-run
        rst_pulse();
        bus.en = 1'b1;
        step(10);
        chk("ar_c9", bus.count, 9);
        rst = 1'b1;
        #2;
        chk("ar_cnt", bus.count, 0);
        chk("ar_flags",
            {bus.warn, bus.timeout, bus.early_fault}, 0);
        rst = 1'b0;
        step(1);
        chk("ar_resume0", bus.count, 0);
        step(1);
        chk("ar_resume1", bus.count, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end
endmodule
